// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes and a one-entry holding register per channel.
// Optional DEMUX_RR_EN: steer beats by an internal round-robin pointer instead of {s1,s0}.
module demux_1x4_reg #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               s0,
   input  logic               s1,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [1:0]         last_sel
);

   logic [4*WIDTH-1:0] data_q,     data_d;
   logic [3:0]         valid_q,    valid_d;
   logic [1:0]         last_sel_q, last_sel_d;
   logic [1:0]         tgt_s;
   logic               ready_s;
   logic               accept_s;

`ifdef DEMUX_RR_EN
   logic [1:0] rr_ptr_q, rr_ptr_d;

   // Target channel comes from the round-robin pointer; the select pins are unused.
   always_comb begin
      tgt_s = rr_ptr_q;
   end

   // Pointer moves on only when a beat is taken, so a full channel stalls the stream.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept_s) begin
         rr_ptr_d = rr_ptr_q + 2'd1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= 2'b00;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   logic unused_sel_s;
   assign unused_sel_s = s0 ^ s1;
`else
   // Target channel comes straight from the select pins.
   always_comb begin
      tgt_s = {s1, s0};
   end
`endif

   // Space exists when the target is empty or is being drained this cycle.
   always_comb begin
      ready_s  = (!valid_q[tgt_s]) || out_ready[tgt_s];
      accept_s = in_valid && ready_s;
   end

   // Per-channel next state: a load wins over a drain, giving back-to-back beats with no bubble.
   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      last_sel_d = last_sel_q;
      for (int k = 0; k < 4; k++) begin
         if (accept_s && (tgt_s == 2'(k))) begin
            valid_d[k]                 = 1'b1;
            data_d[k*WIDTH +: WIDTH]   = in_data;
         end else if (valid_q[k] && out_ready[k]) begin
            valid_d[k]                 = 1'b0;
         end else begin
            valid_d[k]                 = valid_q[k];
         end
      end
      if (accept_s) begin
         last_sel_d = tgt_s;
      end else begin
         last_sel_d = last_sel_q;
      end
   end

   // Holding registers, valid flags and last-select register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         valid_q    <= 4'b0000;
         last_sel_q <= 2'b00;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_sel_q <= last_sel_d;
      end
   end

   assign in_ready  = ready_s;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign last_sel  = last_sel_q;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Directed and randomized self-checking bench for demux_1x4_reg (WIDTH=8).
// Directed steps follow the select-pin build, or the round-robin build when DEMUX_RR_EN is defined.
module tb_demux_1x4_reg;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic           s0, s1;
   logic [4*W-1:0] out_data;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready;
   logic [1:0]     last_sel;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   demux_1x4_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .s0(s0), .s1(s1), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .last_sel(last_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d);
      in_valid = v;
      {s1, s0} = sel;
      in_data  = d;
   endtask

   function automatic logic [W-1:0] chan(input int k);
      return out_data[k*W +: W];
   endfunction

   logic [W-1:0] q[4][$];
   logic [3:0]   mv;
   logic [1:0]   m_last, m_rr, t;
   logic         m_ready, acc;

   initial begin
      rst_n = 1'b0;
      out_ready = 4'b1111;
      drive(1'b0, 2'b00, 8'h00);
      #1;
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_data", out_data, 32'h0);
      check("reset_last", 32'(last_sel), 32'h0);
      check("reset_ready", 32'(in_ready), 32'h1);
      #11 rst_n = 1'b1;
      step();

`ifndef DEMUX_RR_EN
      // Sweep all four selects with every channel ready.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), 8'h01);
         step();
         check("sweep_valid", 32'(out_valid), 32'(4'b0001 << i));
         check("sweep_data", 32'(chan(i)), 32'h01);
         check("sweep_last", 32'(last_sel), 32'(i));
      end
      drive(1'b0, 2'b00, 8'h00);
      step();
      check("sweep_idle", 32'(out_valid), 32'h0);

      // Channel 2 stalled: second beat waits, then hands off with no gap.
      out_ready = 4'b1011;
      drive(1'b1, 2'b10, 8'hA1);
      #1 check("stall_ready1", 32'(in_ready), 32'h1);
      step();
      check("stall_load1", 32'(out_valid), 32'h4);
      check("stall_data1", 32'(chan(2)), 32'hA1);
      drive(1'b1, 2'b10, 8'hA2);
      #1 check("stall_ready0", 32'(in_ready), 32'h0);
      step();
      check("stall_hold", 32'(chan(2)), 32'hA1);
      out_ready[2] = 1'b1;
      #1 check("stall_release", 32'(in_ready), 32'h1);
      step();
      check("stall_nogap", 32'(out_valid), 32'h4);
      check("stall_data2", 32'(chan(2)), 32'hA2);
      drive(1'b0, 2'b00, 8'h00);
      step();
      check("stall_drain", 32'(out_valid), 32'h0);

      // Channel 1 full and stalled does not block channel 3.
      out_ready = 4'b0101;
      drive(1'b1, 2'b01, 8'hB1);
      step();
      drive(1'b1, 2'b11, 8'hB3);
      #1 check("indep_ready", 32'(in_ready), 32'h1);
      step();
      check("indep_valid", 32'(out_valid), 32'hA);
      check("indep_data1", 32'(chan(1)), 32'hB1);
      check("indep_data3", 32'(chan(3)), 32'hB3);
      check("indep_last", 32'(last_sel), 32'h3);

      // Fill every channel, then reset between clock edges.
      out_ready = 4'b0000;
      drive(1'b1, 2'b00, 8'hC0);
      step();
      drive(1'b1, 2'b10, 8'hC2);
      step();
      drive(1'b0, 2'b00, 8'h00);
      check("full_valid", 32'(out_valid), 32'hF);
      check("full_ready", 32'(in_ready), 32'h0);
      #3 rst_n = 1'b0;
      #1;
      check("async_valid", 32'(out_valid), 32'h0);
      check("async_data", out_data, 32'h0);
      check("async_last", 32'(last_sel), 32'h0);
      #2 rst_n = 1'b1;
      out_ready = 4'b1111;
      step();
`else
      // Round-robin: selects held at 11, beats rotate 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'b11, 8'(i + 1));
         step();
         check("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
         check("rr_data", 32'(chan(i % 4)), 32'(i + 1));
      end
      out_ready = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b00, 8'(i + 6));
         step();
      end
      check("rr_ch1_held", 32'(chan(1)), 32'h06);
      drive(1'b1, 2'b00, 8'h0A);
      #1 check("rr_stall_ready", 32'(in_ready), 32'h0);
      step();
      check("rr_stall_ready2", 32'(in_ready), 32'h0);
      check("rr_stall_last", 32'(last_sel), 32'h0);
      out_ready = 4'b1111;
      step();
      check("rr_resume_data", 32'(chan(1)), 32'h0A);
      check("rr_resume_last", 32'(last_sel), 32'h1);
      drive(1'b0, 2'b00, 8'h00);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      step();
`endif

      // Random traffic against a per-channel scoreboard.
      mv = 4'b0000; m_last = 2'b00; m_rr = 2'b00;
      for (int k = 0; k < 4; k++) q[k].delete();
      for (int n = 0; n < 200; n++) begin
         check("rnd_valid", 32'(out_valid), 32'(mv));
         check("rnd_last", 32'(last_sel), 32'(m_last));
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
         out_ready = 4'($urandom);
`ifdef DEMUX_RR_EN
         t = m_rr;
`else
         t = {s1, s0};
`endif
         #1;
         m_ready = !mv[t] || out_ready[t];
         check("rnd_ready", 32'(in_ready), 32'(m_ready));
         acc = in_valid && m_ready;
         for (int k = 0; k < 4; k++) begin
            if (mv[k] && out_ready[k]) begin
               if (q[k].size() == 0) check("rnd_dup", 32'h1, 32'h0);
               else check("rnd_data", 32'(chan(k)), 32'(q[k].pop_front()));
               mv[k] = 1'b0;
            end
         end
         if (acc) begin
            q[t].push_back(in_data);
            mv[t] = 1'b1;
            m_last = t;
            m_rr = m_rr + 2'd1;
         end
         step();
      end
      drive(1'b0, 2'b00, 8'h00);
      out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         if (mv[k]) check("final_data", 32'(chan(k)), 32'(q[k].pop_front()));
         check("final_lost", 32'(q[k].size()), 32'h0);
      end
      step();
      check("final_idle", 32'(out_valid), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
